// File: rtl/mem_ahb_pkg.sv
// Shared definitions for the mem_ahb_ws AHB memory slave: bus codes, FSM states
// and the helper that sizes the byte-lane offset field.
package mem_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;
    localparam logic [2:0] HSIZE_QWORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Number of HADDR bits that select a byte lane within one data word.
    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/mem_ahb_strb.sv
// Combinational byte-strobe generator: lanes covered by a transfer of 2**size bytes
// starting at the given lane offset, plus misaligned / oversize flags.
module mem_ahb_strb
    import mem_ahb_pkg::*;
#(
    parameter  int P_DATA_WIDTH = 32,
    localparam int LB           = lane_bits(P_DATA_WIDTH),
    localparam int NB           = P_DATA_WIDTH / 8
) (
    input  logic [2:0]    size,
    input  logic [LB-1:0] offset,
    output logic [NB-1:0] strb,
    output logic          misaligned,
    output logic          oversize
);

    int len;
    int off;

    // Lanes past the top of the word simply fall off, which truncates misaligned
    // strobes; sizes wider than the bus saturate to every lane.
    always_comb begin
        oversize   = (int'(size) > LB);
        off        = int'(offset);
        len        = oversize ? NB : (1 << size);
        misaligned = ((off & (len - 1)) != 0);
        strb       = '0;
        for (int i = 0; i < NB; i++) begin
            strb[i] = oversize || ((i >= off) && (i < off + len));
        end
    end

endmodule

// File: rtl/mem_ahb_ws.sv
// AHB memory slave with configurable width, capacity and data-phase wait states.
// Define MEM_AHB_ERR_EN to answer out-of-range, misaligned and oversize transfers with ERROR.
module mem_ahb_ws
    import mem_ahb_pkg::*;
#(
    parameter int P_SIZE_IN_BYTES = 8192,
    parameter int P_DATA_WIDTH    = 32,
    parameter int P_WAIT_STATES   = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [P_DATA_WIDTH-1:0] HWDATA,
    output logic [P_DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]              HRESP,
    input  logic                    HREADYin,
    output logic                    HREADYout
);

    localparam int NB    = P_DATA_WIDTH / 8;
    localparam int LB    = lane_bits(P_DATA_WIDTH);
    localparam int AW    = $clog2(P_SIZE_IN_BYTES);
    localparam int IW    = AW - LB;
    localparam int DEPTH = P_SIZE_IN_BYTES / NB;

    state_e                  state;
    state_e                  state_nxt;
    logic [3:0]              cnt;
    logic [IW-1:0]           idx_q;
    logic                    write_q;
    logic [NB-1:0]           strb_q;
    logic                    active_q;
    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    logic [NB-1:0] strb;
    logic          misaligned;
    logic          oversize;
    logic          accept;
    logic          req_err;
    logic          capture_ok;
    logic          commit;
    logic          unused_bits;

    mem_ahb_strb #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_strb (
        .size       (HSIZE),
        .offset     (HADDR[LB-1:0]),
        .strb       (strb),
        .misaligned (misaligned),
        .oversize   (oversize)
    );

    // Capture only while this slave is itself ready, i.e. in the last data-phase cycle.
    assign accept = HSEL & HTRANS[1] & HREADYin & HREADYout;

`ifdef MEM_AHB_ERR_EN
    assign req_err     = (HADDR >= 32'(P_SIZE_IN_BYTES)) || misaligned || oversize;
    assign unused_bits = ^{HBURST, HTRANS[0]};
`else
    assign req_err     = 1'b0;
    assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:AW], misaligned, oversize};
`endif

    assign capture_ok = accept & ~req_err;
    assign commit     = active_q & write_q & HREADYout;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        HREADYout = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state)
            ST_IDLE, ST_ERR2: begin
                if (state == ST_ERR2) HRESP = HRESP_ERROR;
                if (accept && req_err)         state_nxt = ST_ERR1;
                else if (accept && P_WAIT_STATES != 0) state_nxt = ST_WAIT;
                else                           state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                HREADYout = 1'b0;
                if (cnt == 4'd1) state_nxt = ST_IDLE;
            end
            ST_ERR1: begin
                HREADYout = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt      <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            active_q <= 1'b0;
        end else begin
            if (state == ST_WAIT) cnt <= cnt - 4'd1;
            // A data phase ends whenever HREADYout is high; the next one starts only on capture.
            if (HREADYout) begin
                active_q <= capture_ok;
                if (capture_ok) begin
                    cnt     <= 4'(P_WAIT_STATES);
                    idx_q   <= HADDR[AW-1:LB];
                    write_q <= HWRITE;
                    strb_q  <= strb;
                end
            end
        end
    end

    // NOTE: the storage array is deliberately left out of reset; HRESETn clears only
    // the control path, so memory contents survive a bus reset.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
            end
        end
    end

    assign HRDATA = (active_q && !write_q) ? mem[idx_q] : '0;

endmodule

// File: doc/mem_ahb_ws.md
Name: mem_ahb_ws

Overview:
- Next-generation AHB memory slave, successor to the fixed 32-bit zero-wait memory slave paired with bfm_ahb in the dut top.
- Generalised in data width, size and data-phase wait states.
- Adds byte-lane write strobes for all legal HSIZE values and a two-cycle ERROR response.
- Sits directly behind bfm_ahb with HREADYout looped to HREADYin.

Parameters:
- P_SIZE_IN_BYTES, 8192: memory capacity in bytes. Power of 2, at least P_DATA_WIDTH/8.
- P_DATA_WIDTH, 32: HWDATA/HRDATA width. Legal values 32, 64, 128.
- P_WAIT_STATES, 0: number of HREADYout-low cycles inserted in every OKAY data phase. Range 0..15.

Ports:
- HCLK  input  1  AHB clock; all logic on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  32  byte address.
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  input  1  1=write.
- HSIZE  input  3  transfer size, log2 of bytes.
- HBURST  input  3  burst type. Accepted, otherwise ignored.
- HWDATA  input  P_DATA_WIDTH  write data, valid in the data phase.
- HRDATA  output  P_DATA_WIDTH  read data.
- HRESP  output  2  OKAY=00, ERROR=01.
- HREADYin  input  1  bus-wide HREADY.
- HREADYout  output  1  slave ready.

Behaviour:
- Reset (asynchronous, HRESETn low):
  - HREADYout=1, HRESP=OKAY, HRDATA=0, state=IDLE.
  - Any pending write is discarded. Memory contents are untouched.
- Address-phase capture:
  - A transfer is accepted when HSEL & HTRANS[1] & HREADYin on a rising edge.
  - On acceptance, register: address, HWRITE, HSIZE, and a byte strobe.
  - Strobe = ((1<<(1<<HSIZE))-1) << HADDR[log2(P_DATA_WIDTH/8)-1:0].
- IDLE/BUSY transfers, or HSEL low: no capture; the next data phase is OKAY with zero wait.
- Memory word index: addr[log2(P_SIZE_IN_BYTES)-1 : log2(P_DATA_WIDTH/8)]. Upper bits wrap unless the optional feature is enabled.
- State machine (IDLE, WAIT, ERR1, ERR2):
  - IDLE, accepted transfer:
    - P_WAIT_STATES=0: data phase completes in the next cycle with HREADYout=1.
    - Otherwise go to WAIT, load the counter with P_WAIT_STATES and drive HREADYout=0.
  - WAIT: decrement the counter each cycle. When it reaches 1, HREADYout=1 in the following cycle and return to IDLE, or re-capture if HREADYin & a new valid transfer.
  - ERR1: HREADYout=0, HRESP=ERROR. Next state ERR2.
  - ERR2: HREADYout=1, HRESP=ERROR. Address-phase capture is allowed in this cycle.
- Write commit:
  - Occurs on the final data-phase cycle (HREADYout=1) of an OKAY write.
  - Only strobed byte lanes of HWDATA are written.
  - Errored writes never modify memory.
- Read data:
  - HRDATA shows the full memory word at the latched index while a read data phase is active; 0 otherwise.
  - It is sampled by the master when HREADYout=1.
  - Back-to-back write then read to the same address returns the new data with no extra wait. The write commits at the edge before the read data phase.
- Pipelining: a new address phase overlapping the last data-phase cycle is captured. Sustained throughput is 1/(P_WAIT_STATES+1) transfers per cycle.
- HSIZE greater than log2(P_DATA_WIDTH/8): treated as an error when MEM_AHB_ERR_EN is set. Otherwise the strobe saturates to all lanes.
- HBURST is not checked; burst wrap is the master's responsibility.

Optional Feature:
- Macro: MEM_AHB_ERR_EN.
- Defined: these conditions produce ERR1→ERR2, with no wait states and no write:
  - address ≥ P_SIZE_IN_BYTES;
  - misaligned address (HADDR[HSIZE-1:0] != 0);
  - oversize HSIZE.
- Undefined: HRESP is constantly OKAY, addresses wrap modulo P_SIZE_IN_BYTES, and misaligned strobes are truncated to the data width.

Decomposition:
- Package mem_ahb_pkg holds:
  - HTRANS codes, HRESP codes and HSIZE codes;
  - the state enum (IDLE/WAIT/ERR1/ERR2);
  - the function computing the lane-offset width from P_DATA_WIDTH.
- One sub-module, mem_ahb_strb: combinational byte-strobe generator. Inputs HSIZE and the low HADDR bits; outputs the strobe vector and a misaligned flag.

Test Plan:
- P_DATA_WIDTH=32, P_WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back → HRDATA=0xDEADBEEF, HREADYout never low.
- Byte writes 0x11,0x22,0x33,0x44 @0x20..0x23, then word read @0x20 → 0x44332211. Halfword 0xAAAA @0x22, then read → 0xAAAA2211.
- P_WAIT_STATES=3: single read → HREADYout low for exactly 3 cycles, data valid in the 4th. A pipelined NONSEQ is captured in the final cycle.
- MEM_AHB_ERR_EN, write @0x2000 (P_SIZE_IN_BYTES=8192) → HRESP=01 for 2 cycles, HREADYout 0 then 1, memory unchanged. Halfword @0x21 → same ERROR response.
- P_DATA_WIDTH=64: 32-bit write 0x12345678 @0x0C → upper lanes updated only; 64-bit read @0x08 → 0x12345678_xxxxxxxx with the lower word preserved.
- Assert HRESETn low during a WAIT-state write → immediately HREADYout=1, HRESP=00, HRDATA=0; target word unchanged after reset release.
